// File: rtl/cdc_req_ctrl.sv
// Source-side controller for a 4-phase req/ack clock-domain crossing.
// Accepts a word over valid/ready, holds it on xfer_data_o, raises xfer_req_o and
// walks the handshake using the acknowledge after a 2-flop synchronizer.
// Optional feature: define CDC_REQ_TIMEOUT_EN to abort a request that stays
// unacknowledged for TIMEOUT_P cycles and flag it on the sticky err_o.

// Two-flop synchronizer for signals arriving from another clock domain.
module sync2 #(
  parameter int unsigned WIDTH_P = 1
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [WIDTH_P-1:0] d_i,
  output logic [WIDTH_P-1:0] q_o
);

  logic [WIDTH_P-1:0] meta_q;
  logic [WIDTH_P-1:0] sync_q;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

module cdc_req_ctrl #(
  parameter int unsigned WIDTH_P   = 8,
  parameter int unsigned TIMEOUT_P = 1023,
  parameter int unsigned COUNT_W_P = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH_P-1:0]   data_i,
  output logic [WIDTH_P-1:0]   xfer_data_o,
  output logic                 xfer_req_o,
  input  logic                 xfer_ack_i,
  output logic                 done_o,
  output logic [COUNT_W_P-1:0] xfer_count_o,
  output logic                 err_o,
  input  logic                 err_clr_i
);

  typedef enum logic [1:0] {StIdle, StReqHi, StReqLo} state_e;

  state_e               state_q, state_d;
  logic                 req_q, req_d;
  logic [WIDTH_P-1:0]   data_q, data_d;
  logic                 done_q, done_d;
  logic [COUNT_W_P-1:0] cnt_q, cnt_d;
  logic                 ack_s;

  sync2 #(
    .WIDTH_P(1)
  ) u_ack_sync (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .d_i   (xfer_ack_i),
    .q_o   (ack_s)
  );

  // A stale ack still high from the far side blocks a new request.
  assign ready_o = (state_q == StIdle) && !ack_s;

`ifdef CDC_REQ_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_P - 1);

  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        tmo_fire;
`else
  // Timeout disabled: the clear input and timeout length have no effect.
  logic unused_cfg;
  assign unused_cfg = err_clr_i ^ (TIMEOUT_P == 0);
`endif

  // Next-state for the handshake FSM, crossing bus, counter and error flag.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
`ifdef CDC_REQ_TIMEOUT_EN
    tmo_d    = tmo_q;
    tmo_fire = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (valid_i && ready_o) begin
          data_d  = data_i;
          req_d   = 1'b1;
          state_d = StReqHi;
`ifdef CDC_REQ_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      StReqHi: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = StReqLo;
`ifdef CDC_REQ_TIMEOUT_EN
        end else if (tmo_q == TmoLast) begin
          // Abort: drop req and let REQ_LO drain as usual, but never report done.
          req_d    = 1'b0;
          state_d  = StReqLo;
          tmo_fire = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
`endif
        end
      end
      StReqLo: begin
        if (!ack_s) begin
          state_d = StIdle;
          done_d  = 1'b1;
          cnt_d   = cnt_q + COUNT_W_P'(1);
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef CDC_REQ_TIMEOUT_EN
    // Set wins over a simultaneous clear.
    err_d = tmo_fire | (err_q & ~err_clr_i);
`endif
  end

  // State registers; reset aborts any handshake in flight.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef CDC_REQ_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
`ifdef CDC_REQ_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign xfer_req_o   = req_q;
  assign xfer_data_o  = data_q;
  assign done_o       = done_q;
  assign xfer_count_o = cnt_q;
`ifdef CDC_REQ_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_req_ctrl.sv
// Self-checking bench for cdc_req_ctrl: directed handshake scenarios with literal
// expectations plus a randomized far-side responder checked every cycle against
// a handshake-level reference model.
`timescale 1ns/1ps
module tb_cdc_req_ctrl;

  localparam int W  = 8;
  localparam int T  = 16;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          err_clr_i = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic          ready_o, xfer_req_o, done_o, err_o;
  logic [W-1:0]  xfer_data_o;
  logic [CW-1:0] xfer_count_o;
  logic          xfer_ack_i;

  // Far side: loopback (ack = req) or bench-driven ack.
  logic ack_mode = 1'b0;
  logic ack_drv = 1'b0;
  logic agent_en = 1'b0;
  assign xfer_ack_i = ack_mode ? ack_drv : xfer_req_o;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  cdc_req_ctrl #(
    .WIDTH_P  (W),
    .TIMEOUT_P(T),
    .COUNT_W_P(CW)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .xfer_data_o (xfer_data_o),
    .xfer_req_o  (xfer_req_o),
    .xfer_ack_i  (xfer_ack_i),
    .done_o      (done_o),
    .xfer_count_o(xfer_count_o),
    .err_o       (err_o),
    .err_clr_i   (err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // ack history: what the controller can "see" lags the wire by two edges.
  bit m_seen1, m_seen2;
  int m_phase;      // 0 waiting for word, 1 req raised, 2 req dropped
  bit m_req, m_done, m_err;
  int m_data, m_cnt, m_age;

  function automatic bit m_ready();
    return (m_phase == 0) && !m_seen2;
  endfunction

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_seen1 = 0; m_seen2 = 0; m_phase = 0; m_req = 0; m_done = 0; m_err = 0;
      m_data = 0; m_cnt = 0; m_age = 0;
    end else begin
      bit fire;
      fire = 0;
      m_done = 0;
      if (m_phase == 0) begin
        if (valid_i && m_ready()) begin
          m_data = data_i; m_req = 1; m_phase = 1; m_age = 0;
        end
      end else if (m_phase == 1) begin
        m_age++;  // edges since the request went up
        if (m_seen2) begin
          m_req = 0; m_phase = 2;
`ifdef CDC_REQ_TIMEOUT_EN
        end else if (m_age == T) begin
          m_req = 0; m_phase = 2; fire = 1;
`endif
        end
      end else begin
        if (!m_seen2) begin
          m_phase = 0; m_done = 1; m_cnt = (m_cnt + 1) % (1 << CW);
        end
      end
`ifdef CDC_REQ_TIMEOUT_EN
      m_err = fire || (m_err && !err_clr_i);
`else
      m_err = 0;
`endif
      m_seen2 = m_seen1;
      m_seen1 = xfer_ack_i;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk_i) begin
    chk("ready_o", ready_o, m_ready());
    chk("xfer_req_o", xfer_req_o, m_req);
    chk("xfer_data_o", xfer_data_o, m_data[W-1:0]);
    chk("done_o", done_o, m_done);
    chk("xfer_count_o", xfer_count_o, m_cnt[CW-1:0]);
    chk("err_o", err_o, m_err);
    if (rstn_i && done_o) done_seen++;
  end

  // Randomized 4-phase responder.
  always @(posedge clk_i) begin
    if (agent_en) begin
      #2;
      if (xfer_req_o && !ack_drv && $urandom_range(0, 3) == 0) ack_drv = 1'b1;
      else if (!xfer_req_o && ack_drv && $urandom_range(0, 3) == 0) ack_drv = 1'b0;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return xfer_req_o;
      1:       return done_o;
      default: return ready_o;
    endcase
  endfunction

  task automatic wait_until(input int sel, input logic val, input int max, output int n);
    n = 0;
    while (sig(sel) !== val && n < max) begin
      step();
      n++;
    end
    if (sig(sel) !== val) begin
      tests++;
      fails++;
      $display("FAIL wait sel=%0d: got %0b, required %0b within %0d cycles", sel, sig(sel),
               val, max);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, r;
    int acc[3];
    logic [W-1:0] words[3];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;

    // Reset values
    repeat (3) step();
    chk("rst ready", ready_o, 1);
    chk("rst req", xfer_req_o, 0);
    chk("rst data", xfer_data_o, 0);
    chk("rst count", xfer_count_o, 0);
    chk("rst done", done_o, 0);
    rstn_i = 1'b1;
    step();

    // Single loopback transfer of 0xA5
    valid_i = 1; data_i = 8'hA5;
    step();
    valid_i = 0;
    chk("a5 data", xfer_data_o, 8'hA5);
    chk("a5 req", xfer_req_o, 1);
    wait_until(0, 1'b0, 20, n);
    chk("a5 req high edges", n, 3);
    wait_until(1, 1'b1, 20, n);
    chk("a5 done edges", n, 3);
    chk("a5 count", xfer_count_o, 1);
    step();
    chk("a5 done one cycle", done_o, 0);

    // Back-to-back words with valid held high
    d0 = done_seen;
    valid_i = 1; data_i = words[0];
    begin
      int idx;
      idx = 0;
      for (int c = 0; c < 40 && idx < 3; c++) begin
        r = ready_o;
        step();
        if (r) begin
          acc[idx] = c;
          idx++;
          if (idx < 3) data_i = words[idx];
          else valid_i = 0;
        end
        if (idx > 0) chk("b2b hold", xfer_data_o, words[idx-1]);
      end
    end
    chk("b2b spacing 1", acc[1] - acc[0], 7);
    chk("b2b spacing 2", acc[2] - acc[1], 7);
    wait_until(1, 1'b1, 20, n);
    step();
    chk("b2b done pulses", done_seen - d0, 3);
    chk("b2b count", xfer_count_o, 4);

    // Stale ack blocks acceptance
    ack_mode = 1; ack_drv = 1;
    repeat (3) step();
    chk("stale ready", ready_o, 0);
    valid_i = 1; data_i = 8'h5A;
    repeat (4) step();
    chk("stale not taken", xfer_data_o, 8'h33);
    chk("stale count", xfer_count_o, 4);
    ack_drv = 0;
    wait_until(2, 1'b1, 10, n);
    chk("stale ready latency", n, 2);
    step();
    valid_i = 0;
    chk("stale accept", xfer_data_o, 8'h5A);
    ack_mode = 0;
    wait_until(1, 1'b1, 20, n);
    step();
    chk("stale count after", xfer_count_o, 5);

    // Delayed acknowledge
    ack_mode = 1; ack_drv = 0;
    valid_i = 1; data_i = 8'h3C;
    step();
    valid_i = 0;
    repeat (10) step();
    ack_drv = 1;
    wait_until(0, 1'b0, 10, n);
    chk("delay req fall", n, 3);
    repeat (5) step();
    ack_drv = 0;
    wait_until(1, 1'b1, 10, n);
    chk("delay done", n, 3);
    step();
    chk("delay count", xfer_count_o, 6);

`ifdef CDC_REQ_TIMEOUT_EN
    // Timeout abort, then set-vs-clear priority
    d0 = done_seen;
    valid_i = 1; data_i = 8'hC3;
    step();
    valid_i = 0;
    wait_until(0, 1'b0, 40, n);
    chk("tmo req high", n + 1, T);
    chk("tmo err", err_o, 1);
    step();
    chk("tmo no done", done_seen - d0, 0);
    chk("tmo count", xfer_count_o, 6);
    valid_i = 1; data_i = 8'hC4;
    step();
    valid_i = 0;
    repeat (T - 1) step();
    err_clr_i = 1;
    step();
    err_clr_i = 0;
    chk("tmo2 req", xfer_req_o, 0);
    chk("tmo set wins", err_o, 1);
    step();
    err_clr_i = 1;
    step();
    err_clr_i = 0;
    chk("tmo clear", err_o, 0);
`else
    // No timeout: request waits indefinitely
    valid_i = 1; data_i = 8'hC3;
    step();
    valid_i = 0;
    repeat (40) step();
    chk("no tmo req held", xfer_req_o, 1);
    err_clr_i = 1;
    step();
    err_clr_i = 0;
    chk("no tmo err", err_o, 0);
    ack_drv = 1;
    wait_until(0, 1'b0, 10, n);
    ack_drv = 0;
    wait_until(1, 1'b1, 10, n);
    step();
    chk("no tmo count", xfer_count_o, 7);
`endif

    // Reset mid-handshake
    ack_mode = 0;
    valid_i = 1; data_i = 8'hFF;
    step();
    valid_i = 0;
    chk("rst2 accepted", xfer_data_o, 8'hFF);
    repeat (2) step();
    rstn_i = 0;
    #1;
    chk("rst2 req async", xfer_req_o, 0);
    chk("rst2 data async", xfer_data_o, 0);
    chk("rst2 err async", err_o, 0);
    chk("rst2 ready", ready_o, 1);
    repeat (2) step();
    rstn_i = 1;
    step();
    chk("rst2 ready after", ready_o, 1);
    chk("rst2 count", xfer_count_o, 0);

    // Counter wrap: 17 transfers with a 4-bit counter
    for (int k = 0; k < 17; k++) begin
      int g;
      valid_i = 1; data_i = 8'(k);
      g = 0;
      do begin
        r = ready_o;
        step();
        g++;
      end while (!r && g < 20);
      valid_i = 0;
      wait_until(1, 1'b1, 20, n);
    end
    step();
    chk("wrap count", xfer_count_o, 1);

    // Randomized traffic with a randomized responder
    ack_mode = 1; ack_drv = 0; agent_en = 1;
    repeat (2000) begin
      valid_i = ($urandom_range(0, 2) != 0);
      data_i = 8'($urandom);
      err_clr_i = ($urandom_range(0, 15) == 0);
      step();
    end
    valid_i = 0; err_clr_i = 0;
    wait_until(2, 1'b1, 200, n);
    agent_en = 0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cdc_req_ctrl.md
Name: cdc_req_ctrl

Overview:
Source-side controller for a 4-phase req/ack clock-domain crossing of a WIDTH_P-bit word.
- Accepts words via valid/ready and holds each one stable on the crossing bus.
- Drives the request line and synchronizes the returning asynchronous acknowledge through a 2-flop synchronizer (sync2 instance, WIDTH_P=1).
- Sits between a producer in the clk_i domain and a destination-domain receiver that samples xfer_data_o once it sees the request.

Parameters:
WIDTH_P, 8, width of the transferred word
TIMEOUT_P, 1023, cycles req may stay high without ack before abort (timeout feature only); legal range 2..65535
COUNT_W_P, 16, width of completed-transfer counter

Ports:
clk_i  input  1  clock
rstn_i  input  1  asynchronous active-low reset
valid_i  input  1  producer has a word
ready_o  output  1  controller can accept a word this cycle
data_i  input  WIDTH_P  word to transfer
xfer_data_o  output  WIDTH_P  registered crossing bus, stable while handshake active
xfer_req_o  output  1  registered request to destination domain
xfer_ack_i  input  1  acknowledge from destination domain (asynchronous to clk_i)
done_o  output  1  one-cycle pulse per completed transfer
xfer_count_o  output  COUNT_W_P  completed transfers, wraps modulo 2^COUNT_W_P
err_o  output  1  sticky timeout flag
err_clr_i  input  1  clears err_o

Behaviour:
- Reset is rstn_i, asynchronous, active-low; clock is clk_i.
- Reset values: state IDLE, xfer_req_o=0, xfer_data_o=0, done_o=0, xfer_count_o=0, err_o=0, synchronizer flops 0.
- ready_o = (state==IDLE) && !ack_s. It is combinational from registers, so it is 1 during and immediately after reset.
- ack_s is xfer_ack_i after the two synchronizer flops; FSM decisions use ack_s only, never raw xfer_ack_i.
- IDLE: on an edge with valid_i && ready_o, capture data_i into xfer_data_o, set xfer_req_o=1, go to REQ_HI.
- REQ_HI: on an edge with ack_s=1, clear xfer_req_o and go to REQ_LO.
- REQ_LO: on an edge with ack_s=0, go to IDLE, assert done_o for exactly one cycle (the first IDLE cycle), increment xfer_count_o.
- xfer_data_o changes only on acceptance. It holds its value through REQ_HI, REQ_LO and IDLE until the next accept.
- Loopback latency (xfer_ack_i = xfer_req_o): accept at edge E0, req high after E0, req low after E3, done_o high in the cycle after E6, next accept earliest at E7. One transfer per 7 cycles.
- ack_s high while in IDLE (stale ack from the far side) blocks acceptance: ready_o=0 until ack_s falls.
- valid_i while not ready is ignored; data_i is not sampled.
- xfer_count_o wraps from all-ones to 0 without flag.
- Reset mid-handshake aborts immediately: req drops asynchronously, no done_o, count unchanged from 0.

Optional Feature:
Macro CDC_REQ_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to REQ_HI and increments each REQ_HI cycle.
  - If ack_s is still 0 on the edge where the counter equals TIMEOUT_P-1, xfer_req_o is cleared and the FSM goes to REQ_LO. Req has then been high exactly TIMEOUT_P cycles.
  - err_o is set, and the abort produces no done_o and no count increment. REQ_LO then waits for ack_s=0 as normal.
  - err_clr_i clears err_o. Simultaneous set and clear: set wins.
- Undefined: no timeout counter, REQ_HI waits indefinitely, err_o is constant 0, err_clr_i is ignored.

Test Plan:
- Reset then loopback ack, send data_i=0xA5 with valid_i held 1 cycle: xfer_data_o=0xA5 after E0, req high E0..E3, done_o pulse after E6, xfer_count_o=1.
- Loopback, valid_i held high, 3 words 0x11/0x22/0x33: accepts at E0/E7/E14, xfer_data_o stable through each handshake, 3 done pulses, count=3.
- xfer_ack_i forced 1 before any request: ready_o=0, valid_i with 0x5A not accepted; release ack: ready_o rises 2 cycles later and 0x5A is accepted.
- Delayed ack (far side raises ack 10 cycles after req, drops it 5 cycles after req falls): req falls 3 cycles after ack rises, done_o 3 cycles after ack falls.
- With COUNT_W_P=4, complete 17 transfers: xfer_count_o reads 1.
- CDC_REQ_TIMEOUT_EN, TIMEOUT_P=16, ack tied 0: req high exactly 16 cycles, then err_o=1, no done_o, count 0. Assert err_clr_i together with a second timeout: err_o stays 1. Clear alone: err_o=0.
- Assert rstn_i low 2 cycles after accepting 0xFF: xfer_req_o, xfer_data_o and err_o go to 0 immediately, and the FSM restarts in IDLE with ready_o=1.
